// File: rtl/router_pkg.sv
// Shared definitions for the router synchroniser.
//   TIMEOUT_DEF : default stall cycles before a FIFO soft reset
//   NUM_PORTS   : number of output FIFOs
//   CNT_W       : stall counter width
//   addr_e      : destination address encodings
//   addr_onehot : address to one-hot FIFO select (invalid address -> none)
package router_pkg;

  localparam int TIMEOUT_DEF = 30;
  localparam int NUM_PORTS   = 3;
  localparam int CNT_W       = 5;

  typedef enum logic [1:0] {
    ADDR_P0  = 2'b00,
    ADDR_P1  = 2'b01,
    ADDR_P2  = 2'b10,
    ADDR_INV = 2'b11
  } addr_e;

  function automatic logic [NUM_PORTS-1:0] addr_onehot(input addr_e a);
    logic [NUM_PORTS-1:0] oh;
    oh = '0;
    case (a)
      ADDR_P0: oh = 3'b001;
      ADDR_P1: oh = 3'b010;
      ADDR_P2: oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-port stall watchdog.
// Counts consecutive cycles where the port has valid data but is not being
// read. When the TIMEOUT-th such cycle ends, soft_reset is registered high
// for one cycle and the count restarts from zero.
//   clock      : rising-edge clock
//   reset      : synchronous active-high reset
//   vld        : port holds data (FIFO not empty)
//   read_enb   : downstream is reading this port
//   soft_reset : one-cycle flush pulse
module router_sync_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic vld,
  input  logic read_enb,
  output logic soft_reset
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic             stall;

  // A read wins over the stall, so a read in the would-be last cycle
  // clears the count and suppresses the pulse.
  assign stall = vld & ~read_enb;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (stall) begin
      if (cnt == LAST) begin
        cnt        <= '0;
        soft_reset <= 1'b1;
      end else begin
        cnt        <= cnt + 1'b1;
        soft_reset <= 1'b0;
      end
    end else begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync.sv
// Router synchroniser: latches the packet destination address, steers the
// FIFO write enable, reports the addressed FIFO's full flag, exposes per-port
// data-valid flags and flushes any FIFO whose data sits unread too long.
//   clock, reset              : clock, synchronous active-high reset
//   detect_add, data_in[1:0]  : header strobe and destination address
//   write_enb_reg             : request to write the current byte
//   read_enb_0/1/2            : downstream read strobes
//   empty_0/1/2, full_0/1/2   : FIFO status flags
//   write_enb[2:0]            : one-hot FIFO write enable
//   fifo_full                 : full flag of the addressed FIFO
//   vld_out_0/1/2             : per-port data valid
//   soft_reset_0/1/2          : per-FIFO flush pulse
module router_sync
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  addr_e                addr;
  logic [NUM_PORTS-1:0] vld;
  logic [NUM_PORTS-1:0] rd;
  logic [NUM_PORTS-1:0] sr;

  // Address register. A write in the same cycle as detect_add still uses
  // the old address; the new one takes effect from the next cycle.
  always_ff @(posedge clock) begin
    if (reset)           addr <= ADDR_P0;
    else if (detect_add) addr <= addr_e'(data_in);
  end

  assign write_enb = write_enb_reg ? addr_onehot(addr) : '0;

  always_comb begin
    fifo_full = 1'b0;
    case (addr)
      ADDR_P0: fifo_full = full_0;
      ADDR_P1: fifo_full = full_1;
      ADDR_P2: fifo_full = full_2;
      default: fifo_full = 1'b0;
    endcase
  end

  assign vld = ~{empty_2, empty_1, empty_0};
  assign rd  = {read_enb_2, read_enb_1, read_enb_0};

  assign {vld_out_2, vld_out_1, vld_out_0} = vld;

  // One independent watchdog per output port.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timer
    router_sync_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clock      (clock),
      .reset      (reset),
      .vld        (vld[i]),
      .read_enb   (rd[i]),
      .soft_reset (sr[i])
    );
  end

  assign {soft_reset_2, soft_reset_1, soft_reset_0} = sr;

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync. Stimulus pushes the expected outputs for
// each driven cycle into a queue; a monitor pops and compares mid-cycle.
module tb_router_sync;

  logic       clock = 1'b0;
  logic       reset;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic [2:0] rd;
  logic [2:0] em;
  logic [2:0] fu;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  typedef struct {
    string      nm;
    logic [2:0] we;
    logic       ff;
    logic [2:0] vld;
    logic [2:0] sr;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clock = ~clock;

  router_sync dut (
    .clock         (clock),
    .reset         (reset),
    .detect_add    (detect_add),
    .data_in       (data_in),
    .write_enb_reg (write_enb_reg),
    .read_enb_0    (rd[0]),
    .read_enb_1    (rd[1]),
    .read_enb_2    (rd[2]),
    .empty_0       (em[0]),
    .empty_1       (em[1]),
    .empty_2       (em[2]),
    .full_0        (fu[0]),
    .full_1        (fu[1]),
    .full_2        (fu[2]),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .vld_out_0     (vld_out_0),
    .vld_out_1     (vld_out_1),
    .vld_out_2     (vld_out_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2)
  );

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clock) begin
    if (sbq.size() > 0) begin
      exp_t e;
      logic [9:0] got, want;
      e    = sbq.pop_front();
      got  = {write_enb, fifo_full, vld_out_2, vld_out_1, vld_out_0,
              soft_reset_2, soft_reset_1, soft_reset_0};
      want = {e.we, e.ff, e.vld, e.sr};
      n_tot++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got we=%b ff=%b vld=%b sr=%b, want we=%b ff=%b vld=%b sr=%b",
                    e.nm, got[9:7], got[6], got[5:3], got[2:0],
                    e.we, e.ff, e.vld, e.sr);
    end
  end

  // Push expectation for the cycle whose inputs are now applied, then
  // advance to just after the next rising edge.
  task automatic cyc(input string nm, input logic [2:0] we, input logic ff,
                     input logic [2:0] sr);
    exp_t e;
    e.nm = nm; e.we = we; e.ff = ff; e.vld = ~em; e.sr = sr;
    sbq.push_back(e);
    @(posedge clock); #1;
  endtask

  task automatic idle();
    detect_add = 0; write_enb_reg = 0; rd = 3'b000; em = 3'b111; fu = 3'b000;
  endtask

  initial begin
    reset = 1; data_in = 2'b00; idle();
    repeat (2) @(posedge clock);
    #1 reset = 0;

    // Reset state: address 00
    fu = 3'b001;
    cyc("reset_state", 3'b000, 1'b1, 3'b000);
    write_enb_reg = 1; fu = 3'b110;
    cyc("reset_addr_we", 3'b001, 1'b0, 3'b000);

    // Decode address 10
    idle(); detect_add = 1; data_in = 2'b10; fu = 3'b100;
    cyc("det_10_old", 3'b000, 1'b0, 3'b000);
    detect_add = 0; write_enb_reg = 1;
    cyc("addr10_we", 3'b100, 1'b1, 3'b000);
    fu = 3'b011;
    cyc("addr10_full2_low", 3'b100, 1'b0, 3'b000);

    // Decode address 11 (invalid)
    write_enb_reg = 0; detect_add = 1; data_in = 2'b11;
    cyc("det_11_old", 3'b000, 1'b0, 3'b000);
    detect_add = 0; write_enb_reg = 1; fu = 3'b111;
    cyc("addr11_we", 3'b000, 1'b0, 3'b000);

    // Same-cycle detect and write
    idle(); detect_add = 1; data_in = 2'b01;
    cyc("det_01", 3'b000, 1'b0, 3'b000);
    data_in = 2'b00; write_enb_reg = 1; fu = 3'b010;
    cyc("same_cycle_old", 3'b010, 1'b1, 3'b000);
    detect_add = 0;
    cyc("same_cycle_new", 3'b001, 1'b0, 3'b000);

    // Vld follows ~empty independent of address
    idle(); em = 3'b010;
    cyc("vld_pattern", 3'b000, 1'b0, 3'b000);

    // Timeout on port 1: pulses in cycles 31 and 61
    idle(); em = 3'b101;
    for (int k = 1; k <= 65; k++)
      cyc($sformatf("timeout_p1_c%0d", k), 3'b000, 1'b0,
          (k == 31 || k == 61) ? 3'b010 : 3'b000);
    idle();
    cyc("timeout_p1_clear", 3'b000, 1'b0, 3'b000);

    // Read in cycle 30 suppresses the pulse; fresh 30-cycle stall needed
    idle(); em = 3'b101;
    for (int k = 1; k <= 61; k++) begin
      rd = (k == 30) ? 3'b010 : 3'b000;
      cyc($sformatf("read_block_c%0d", k), 3'b000, 1'b0,
          (k == 61) ? 3'b010 : 3'b000);
    end
    idle();
    cyc("read_block_clear", 3'b000, 1'b0, 3'b000);

    // Reset mid-count on port 0
    idle(); em = 3'b110;
    for (int k = 1; k <= 20; k++)
      cyc($sformatf("rst_mid_pre_c%0d", k), 3'b000, 1'b0, 3'b000);
    reset = 1;
    cyc("rst_mid_rst", 3'b000, 1'b0, 3'b000);
    reset = 0;
    for (int j = 1; j <= 31; j++)
      cyc($sformatf("rst_mid_post_c%0d", j), 3'b000, 1'b0,
          (j == 31) ? 3'b001 : 3'b000);
    idle();
    cyc("rst_mid_clear", 3'b000, 1'b0, 3'b000);

    // Ports 0 and 2 stalled together
    idle(); em = 3'b010;
    for (int k = 1; k <= 32; k++)
      cyc($sformatf("indep_c%0d", k), 3'b000, 1'b0,
          (k == 31) ? 3'b101 : 3'b000);
    idle();
    cyc("indep_clear", 3'b000, 1'b0, 3'b000);

    @(negedge clock); #1;
    if (sbq.size() != 0) begin
      n_tot++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
